// File: rtl/pong_match_ctrl.sv
// Match controller for a pong game: attract/serve/play/game-over sequencing,
// score keeping, serve timing and a small priority sound arbiter.
module pong_match_ctrl #(
   parameter int unsigned WIN_SCORE    = 15,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned OVER_FRAMES  = 300,
   parameter int unsigned SND_FRAMES   = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic       frame,
   input  logic       start,
   input  logic [1:0] point,
   input  logic       wallHit,
   input  logic       padHit,
   output logic       game,
   output logic       serve,
   output logic       serveDir,
   output logic [3:0] up1,
   output logic [3:0] up2,
   output logic [1:0] winner,
   output logic       sndOn,
   output logic [1:0] sndSel
);

   localparam int unsigned TMR_W   = 9;
   localparam int unsigned SCORE_W = 4;
   localparam int unsigned SND_W   = 8;

   localparam logic [TMR_W-1:0]   SERVE_LOAD = TMR_W'(SERVE_FRAMES - 1);
   localparam logic [TMR_W-1:0]   OVER_LOAD  = TMR_W'(OVER_FRAMES - 1);
   localparam logic [SND_W-1:0]   SND_SHORT  = SND_W'(SND_FRAMES - 1);
   localparam logic [SND_W-1:0]   SND_LONG   = SND_W'(2 * SND_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   localparam logic [1:0] SEL_PAD   = 2'd0;
   localparam logic [1:0] SEL_WALL  = 2'd1;
   localparam logic [1:0] SEL_POINT = 2'd2;

   typedef enum logic [1:0] {
      ATTRACT    = 2'd0,
      SERVE_WAIT = 2'd1,
      PLAY       = 2'd2,
      GAMEOVER   = 2'd3
   } state_t;

   state_t              state, state_d;
   logic [TMR_W-1:0]    timer, timer_d;
   logic [SND_W-1:0]    snd_cnt, snd_cnt_d;
   logic                prev_start, prev_start_d;
   logic                game_d, serve_d, serve_dir_d, snd_on_d;
   logic [SCORE_W-1:0]  up1_d, up2_d, up1_inc, up2_inc;
   logic [1:0]          winner_d, snd_sel_d, ev_sel;
   logic                tick, press, score1, score2, scored, ev_take;

   // State and datapath registers; nothing moves while ce is low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ATTRACT;
         timer      <= '0;
         snd_cnt    <= '0;
         prev_start <= 1'b1;
         game       <= 1'b0;
         serve      <= 1'b0;
         serveDir   <= 1'b0;
         up1        <= '0;
         up2        <= '0;
         winner     <= 2'b00;
         sndOn      <= 1'b0;
         sndSel     <= SEL_PAD;
      end else if (ce) begin
         state      <= state_d;
         timer      <= timer_d;
         snd_cnt    <= snd_cnt_d;
         prev_start <= prev_start_d;
         game       <= game_d;
         serve      <= serve_d;
         serveDir   <= serve_dir_d;
         up1        <= up1_d;
         up2        <= up2_d;
         winner     <= winner_d;
         sndOn      <= snd_on_d;
         sndSel     <= snd_sel_d;
      end
   end

   // Next-state, score and sound logic; serve defaults low so it lasts one ce-cycle.
   always_comb begin
      state_d      = state;
      timer_d      = timer;
      snd_cnt_d    = snd_cnt;
      prev_start_d = prev_start;
      serve_d      = 1'b0;
      serve_dir_d  = serveDir;
      up1_d        = up1;
      up2_d        = up2;
      winner_d     = winner;
      snd_on_d     = sndOn;
      snd_sel_d    = sndSel;

      tick    = ce & frame;
      press   = start & ~prev_start;
      up1_inc = up1 + 4'd1;
      up2_inc = up2 + 4'd1;
      score1  = (state == PLAY) & point[0];
      score2  = (state == PLAY) & ~point[0] & point[1];
      scored  = score1 | score2;
      ev_sel  = scored ? SEL_POINT : (wallHit ? SEL_WALL : SEL_PAD);
      ev_take = (game | scored) & (scored | wallHit | padHit) &
                (~sndOn | (ev_sel >= sndSel));

      if (tick) begin
         prev_start_d = start;
         unique case (state)
            ATTRACT: begin
               if (press) begin
                  up1_d       = '0;
                  up2_d       = '0;
                  winner_d    = 2'b00;
                  serve_dir_d = 1'b0;
                  timer_d     = SERVE_LOAD;
                  state_d     = SERVE_WAIT;
               end
            end
            SERVE_WAIT: begin
               if (timer == '0) begin
                  state_d = PLAY;
                  serve_d = 1'b1;
               end else begin
                  timer_d = timer - 9'd1;
               end
            end
            PLAY: begin
               if (score1) up1_d = up1_inc;
               if (score2) up2_d = up2_inc;
               if ((score1 && up1_inc == WIN) || (score2 && up2_inc == WIN)) begin
                  winner_d = score1 ? 2'b01 : 2'b10;
                  timer_d  = OVER_LOAD;
                  state_d  = GAMEOVER;
               end else if (scored) begin
                  serve_dir_d = score1;
                  timer_d     = SERVE_LOAD;
                  state_d     = SERVE_WAIT;
               end
            end
            GAMEOVER: begin
               if (timer == '0) state_d = ATTRACT;
               else             timer_d = timer - 9'd1;
            end
            default: state_d = ATTRACT;
         endcase

         if (ev_take) begin
            snd_on_d  = 1'b1;
            snd_sel_d = ev_sel;
            snd_cnt_d = (ev_sel == SEL_POINT) ? SND_LONG : SND_SHORT;
         end else if (sndOn) begin
            if (snd_cnt == '0) snd_on_d  = 1'b0;
            else               snd_cnt_d = snd_cnt - 8'd1;
         end

         if (state != ATTRACT && state_d == ATTRACT) snd_on_d = 1'b0;
      end

      game_d = (state_d == SERVE_WAIT) || (state_d == PLAY);
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized bench for pong_match_ctrl against a tick-level behavioural model
// that counts remaining frames rather than mirroring the controller's timers.
module tb_pong_match_ctrl;

   localparam int WIN_SCORE    = 15;
   localparam int SERVE_FRAMES = 60;
   localparam int OVER_FRAMES  = 300;
   localparam int SND_FRAMES   = 6;
   localparam int CYCLES       = 60000;

   logic       clock = 1'b0;
   logic       reset, ce, frame, start, wallHit, padHit;
   logic [1:0] point;
   logic       game, serve, serveDir, sndOn;
   logic [3:0] up1, up2;
   logic [1:0] winner, sndSel;

   int checks   = 0;
   int failures = 0;

   pong_match_ctrl #(
      .WIN_SCORE(WIN_SCORE), .SERVE_FRAMES(SERVE_FRAMES),
      .OVER_FRAMES(OVER_FRAMES), .SND_FRAMES(SND_FRAMES)
   ) dut (
      .clock(clock), .reset(reset), .ce(ce), .frame(frame), .start(start),
      .point(point), .wallHit(wallHit), .padHit(padHit), .game(game),
      .serve(serve), .serveDir(serveDir), .up1(up1), .up2(up2),
      .winner(winner), .sndOn(sndOn), .sndSel(sndSel)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 waiting to serve, 2 rally, 3 match over.
   int m_phase, m_left, m_s1, m_s2, m_win, m_snd_sel, m_snd_left;
   bit m_prev_start, m_serve, m_dir, m_snd_on;

   task automatic model_reset();
      m_phase = 0; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_snd_sel = 0; m_snd_left = 0; m_prev_start = 1'b1;
      m_serve = 1'b0; m_dir = 1'b0; m_snd_on = 1'b0;
   endtask

   task automatic model_edge();
      bit was_game, scored, serve_now, press;
      int who, pri;
      if (!ce) return;
      serve_now = 1'b0;
      if (frame) begin
         was_game = (m_phase == 1 || m_phase == 2);
         scored   = 1'b0;
         who      = 0;
         press    = start && !m_prev_start;
         m_prev_start = start;
         case (m_phase)
            0: if (press) begin
               m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 1'b0;
               m_left = SERVE_FRAMES; m_phase = 1;
            end
            1: begin
               m_left--;
               if (m_left == 0) begin m_phase = 2; serve_now = 1'b1; end
            end
            2: if (point != 2'b00) begin
               scored = 1'b1;
               who = point[0] ? 1 : 2;
               if (who == 1) m_s1++; else m_s2++;
               if ((who == 1 ? m_s1 : m_s2) == WIN_SCORE) begin
                  m_win = (who == 1) ? 1 : 2;
                  m_phase = 3; m_left = OVER_FRAMES;
               end else begin
                  m_dir = (who == 1);
                  m_phase = 1; m_left = SERVE_FRAMES;
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) m_phase = 0;
            end
         endcase
         pri = scored ? 2 : wallHit ? 1 : padHit ? 0 : -1;
         if ((was_game || scored) && pri >= 0 && (!m_snd_on || pri >= m_snd_sel)) begin
            m_snd_on = 1'b1; m_snd_sel = pri;
            m_snd_left = (pri == 2) ? 2 * SND_FRAMES : SND_FRAMES;
         end else if (m_snd_on) begin
            m_snd_left--;
            if (m_snd_left == 0) m_snd_on = 1'b0;
         end
         if (m_phase == 0) m_snd_on = 1'b0;
      end
      m_serve = serve_now;
   endtask

   task automatic compare_all(input string ctx);
      check({ctx, ".game"},     32'(game),     32'((m_phase == 1 || m_phase == 2) ? 1 : 0));
      check({ctx, ".serve"},    32'(serve),    32'(m_serve));
      check({ctx, ".serveDir"}, 32'(serveDir), 32'(m_dir));
      check({ctx, ".up1"},      32'(up1),      32'(m_s1));
      check({ctx, ".up2"},      32'(up2),      32'(m_s2));
      check({ctx, ".winner"},   32'(winner),   32'(m_win));
      check({ctx, ".sndOn"},    32'(sndOn),    32'(m_snd_on));
      check({ctx, ".sndSel"},   32'(sndSel),   32'(m_snd_sel));
   endtask

   // Asynchronous reset pulse mid-cycle with start held high.
   task automatic reset_pulse();
      start = 1'b1;
      #1 reset = 1'b0;
      #1 model_reset();
      compare_all("async_rst");
      repeat (2) @(posedge clock);
      #1 compare_all("in_rst");
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      bit did_reset = 1'b0;
      reset = 1'b0; ce = 1'b0; frame = 1'b0; start = 1'b0;
      point = 2'b00; wallHit = 1'b0; padHit = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      compare_all("por");
      reset = 1'b1;

      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(negedge clock);
         if ((!did_reset && cyc > 15000 && m_phase == 2) || cyc == 45000) begin
            did_reset = 1'b1;
            reset_pulse();
         end
         ce      = ($urandom_range(0, 7) != 0);
         frame   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) start = ~start;
         point   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         wallHit = ($urandom_range(0, 19) == 0);
         padHit  = ($urandom_range(0, 14) == 0);
         @(posedge clock);
         model_edge();
         #1 compare_all("run");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 15, points needed to win (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames between point or start and serve (1..511).
REQ-003 SHALL have parameter OVER_FRAMES, default 300, frames held in game-over before attract (1..511).
REQ-004 SHALL have parameter SND_FRAMES, default 6, frames per pad or wall sound; point sound lasts 2*SND_FRAMES (1..127).
REQ-005 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ce, input, 1, clock enable; no state changes when ce=0.
REQ-008 SHALL have port frame, input, 1, end-of-frame strobe; the "frame tick" is ce=1 and frame=1 on the same edge.
REQ-009 SHALL have port start, input, 1, start button, level.
REQ-010 SHALL have port point, input, 2, point scored; bit0 scores player 1, bit1 scores player 2.
REQ-011 SHALL have port wallHit, input, 1, ball hit top or bottom wall.
REQ-012 SHALL have port padHit, input, 1, ball hit a paddle.
REQ-013 SHALL have ports game, serve and serveDir, each output, 1: play enabled, serve pulse, serve direction (0 = toward player 2, 1 = toward player 1).
REQ-014 SHALL have ports up1 and up2, each output, 4, player 1 and player 2 scores.
REQ-015 SHALL have port winner, output, 2, one-hot winner (bit0 = player 1), 00 while no winner.
REQ-016 SHALL have ports sndOn (output, 1, sound gate) and sndSel (output, 2, tone: 0 pad, 1 wall, 2 point).

Function
REQ-017 SHALL sample start, point, wallHit and padHit only on frame ticks; all FSM, timer, score and sound updates occur only on frame ticks, except clearing of serve.
REQ-018 SHALL detect a start press as start=1 at this frame tick and start=0 at the previous frame tick.
REQ-019 SHALL implement FSM states ATTRACT, SERVE_WAIT, PLAY, GAMEOVER; game=1 exactly in SERVE_WAIT and PLAY.
REQ-020 In ATTRACT, a start press SHALL clear up1, up2 and winner, set serveDir=0, load the 9-bit timer with SERVE_FRAMES-1, and go to SERVE_WAIT.
REQ-021 In SERVE_WAIT, the timer SHALL decrement per tick; on a tick with timer=0, the FSM SHALL go to PLAY and set serve=1.
REQ-022 serve SHALL clear on the next clock edge with ce=1, so it is exactly one ce-cycle wide.
REQ-023 In PLAY, point=01 SHALL increment up1 and point=10 SHALL increment up2; point=11 SHALL increment up1 only (player 1 priority).
REQ-024 On a score in PLAY where the new score equals WIN_SCORE: set winner, load OVER_FRAMES-1, go to GAMEOVER.
REQ-025 On any other score in PLAY: set serveDir=1 if player 1 scored else 0, load SERVE_FRAMES-1, go to SERVE_WAIT.
REQ-026 In GAMEOVER, the timer SHALL decrement per tick; at timer=0 go to ATTRACT; up1, up2 and winner hold until the next start.
REQ-027 Start presses in SERVE_WAIT, PLAY or GAMEOVER SHALL be ignored; point inputs outside PLAY SHALL be ignored.
REQ-028 Score counters SHALL never wrap; the WIN_SCORE transition guarantees up1, up2 <= WIN_SCORE.
REQ-029 The sound arbiter SHALL accept events only when game=1 or on the scoring tick itself, with priority point > wallHit > padHit.
REQ-030 A new event whose priority is >= the current sndSel (or any event while sndOn=0) SHALL set sndSel, set sndOn=1 and reload the 8-bit sound counter; a lower-priority event while sndOn=1 SHALL be ignored.
REQ-031 The sound counter SHALL decrement per tick; sndOn SHALL clear on the tick where the counter is 0.
REQ-032 Entering ATTRACT SHALL force sndOn=0.

Reset
REQ-033 reset=0 SHALL asynchronously force state=ATTRACT, game=0, serve=0, serveDir=0, up1=up2=0, winner=00, sndOn=0, sndSel=0, timers=0, previous start sample=1, so a held start does not trigger a press.
REQ-034 Release of reset SHALL take effect on the next clock edge, including mid-rally; no outputs glitch beyond the async clear.

Verification
REQ-035 Start press in ATTRACT -> game=1 on that tick; exactly 60 ticks later serve=1 for one ce-cycle; state=PLAY.
REQ-036 In PLAY, point=10 -> up2=1, serveDir=0, SERVE_WAIT, sndOn=1, sndSel=2 for 12 ticks.
REQ-037 Drive up1 to 14, then point=01 -> up1=15, winner=01, game=0; after 300 ticks state=ATTRACT, up1 still 15; start -> scores 0.
REQ-038 point=11 in PLAY -> up1+1, up2 unchanged.
REQ-039 padHit, then wallHit 2 ticks later -> sndSel 0 then 1 with counter reloaded; padHit during wall sound -> ignored.
REQ-040 reset pulse low mid-PLAY with start held high -> all outputs at reset values immediately; after release no start press until start toggles low then high.
